// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
// Shared definitions for the sequential restoring divider.
//   - div_state_t       : controller states (IDLE / RUN / DONE)
//   - DIV_WIDTH_DEFAULT : default operand/result width
//   - div_cnt_bits()    : width of an iteration counter able to hold WIDTH
// -----------------------------------------------------------------------------
package seq_divider_pkg;

  localparam int DIV_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Bits needed to count down from 'width' to 0 inclusive.
  function automatic int div_cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_cla_subtractor.sv
// -----------------------------------------------------------------------------
// cla_subtractor
// N-bit subtractor built as a carry-lookahead adder computing a + ~b + 1.
// Bits are grouped in blocks of four: each block produces a group generate /
// propagate pair, block carries are resolved from those, and the carries
// inside a block are expanded from the block carry-in.
//
// Ports:
//   a      in  N  minuend
//   b      in  N  subtrahend
//   diff   out N  a - b (modulo 2^N)
//   borrow out 1  1 when a < b (inverted carry out of the adder)
// -----------------------------------------------------------------------------
module cla_subtractor #(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  localparam int GRP = 4;
  localparam int NG  = (N + GRP - 1) / GRP;

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N-1:0] c;
  logic [NG:0]  gc;

  // Adding ~b: generate/propagate against the inverted subtrahend.
  assign g = a & ~b;
  assign p = a ^ ~b;

  always_comb begin
    logic gg;
    logic pp;
    gg    = 1'b0;
    pp    = 1'b1;
    c     = '0;
    gc    = '0;
    gc[0] = 1'b1;  // the +1 of two's complement enters as carry-in
    for (int k = 0; k < NG; k++) begin
      // Running prefix (gg, pp) over the bits of block k seen so far; each
      // bit carry is prefix_generate | prefix_propagate & block_carry_in.
      gg = 1'b0;
      pp = 1'b1;
      for (int j = 0; j < GRP; j++) begin
        if (k * GRP + j < N) begin
          c[k*GRP+j] = gg | (pp & gc[k]);
          gg         = g[k*GRP+j] | (p[k*GRP+j] & gg);
          pp         = pp & p[k*GRP+j];
        end
      end
      gc[k+1] = gg | (pp & gc[k]);
    end
  end

  assign diff   = p ^ c;
  assign borrow = ~gc[NG];

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Unsigned sequential restoring divider, one quotient bit per clock.
// A start seen in IDLE or DONE captures the operands; WIDTH RUN cycles later
// the controller sits in DONE for one cycle with done high and the results
// valid. Results hold until the next accepted start.
//
// Optional feature (compile-time macro DIV_ZERO_DETECT_EN):
//   defined   : a zero divisor skips RUN, goes straight to DONE with
//               div_zero=1, quotient=all ones, remainder=dividend.
//   undefined : div_zero is tied low; a zero divisor runs the normal
//               algorithm, which naturally yields all ones / dividend.
//
// Ports:
//   clk       in  1      rising-edge clock
//   rst       in  1      synchronous active-high reset
//   start     in  1      begin a division (ignored while busy)
//   dividend  in  WIDTH  unsigned numerator, captured on accepted start
//   divisor   in  WIDTH  unsigned denominator, captured on accepted start
//   busy      out 1      high during RUN
//   done      out 1      one-cycle pulse, results valid
//   quotient  out WIDTH  unsigned quotient
//   remainder out WIDTH  unsigned remainder
//   div_zero  out 1      with done: captured divisor was zero
// -----------------------------------------------------------------------------
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = div_cnt_bits(WIDTH);

  div_state_t       state;
  div_state_t       state_nxt;

  logic [WIDTH:0]   rem;       // partial remainder
  logic [WIDTH-1:0] quo;       // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs;       // captured divisor
  logic [CW-1:0]    cnt;       // remaining RUN iterations

  logic [WIDTH:0]   shifted;   // partial remainder after the left shift
  logic [WIDTH:0]   trial;
  logic             trial_borrow;
  logic             accept;
  logic             zero_skip;

  // The restored remainder is always below the divisor, so its top bit is
  // zero whenever it is shifted; only the lower WIDTH bits feed the shift.
  logic             unused_rem_msb;
  assign unused_rem_msb = rem[WIDTH];

  assign accept = start && (state != RUN);

`ifdef DIV_ZERO_DETECT_EN
  assign zero_skip = (divisor == '0);
`else
  assign zero_skip = 1'b0;
`endif

  assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};

  cla_subtractor #(
    .N (WIDTH + 1)
  ) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs}),
    .diff   (trial),
    .borrow (trial_borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = zero_skip ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CW'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_nxt = zero_skip ? DONE : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Divisor is pure data: only meaningful after a start, never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvs <= divisor;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo <= '0;
      rem <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (zero_skip) begin
        quo <= '1;
        rem <= {1'b0, dividend};
        cnt <= '0;
      end else begin
        quo <= dividend;
        rem <= '0;
        cnt <= CW'(WIDTH);
      end
    end else if (state == RUN) begin
      cnt <= cnt - CW'(1);
      if (!trial_borrow) begin
        rem <= trial;
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= shifted;
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem[WIDTH-1:0];

`ifdef DIV_ZERO_DETECT_EN
  logic dz_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      dz_flag <= 1'b0;
    end else if (accept) begin
      dz_flag <= zero_skip;
    end
  end

  assign div_zero = done & dz_flag;
`else
  assign div_zero = 1'b0;
`endif

endmodule
